// File: rtl/avr_serial_tx.sv
// Buffered 8N1 UART transmitter for the FPGA-to-AVR serial line.
// Fabric bytes are queued in a small FIFO and sent LSB first whenever the AVR is not busy.
module avr_serial_tx #(
  parameter int CLK_PER_BIT = 100,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   data_in,
  input  logic                         data_valid,
  output logic                         data_ready,
  input  logic                         avr_rx_busy,
  output logic                         tx,
  output logic                         tx_active,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [1:0]                   state_dbg
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             busy_meta;
  logic             busy_sync;
  logic             push;
  logic             pop;

  // Handshake: a byte transfers on any rising edge where data_valid && data_ready
  // (and rst is low); data_in must be stable while data_valid is high, and
  // data_ready depends only on fifo_count, never on data_valid.
  assign data_ready = (fifo_count != COUNT_FULL);
  assign push       = data_valid && data_ready && !rst;
  assign pop        = (state == IDLE) && (fifo_count != '0) && !busy_sync;
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Synchronizer resets to "busy" so nothing is sent before the true level arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_meta <= 1'b1;
      busy_sync <= 1'b1;
    end else begin
      busy_meta <= avr_rx_busy;
      busy_sync <= busy_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      tx_active <= 1'b0;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift     <= mem[rd_ptr];
            cnt       <= '0;
            bit_idx   <= '0;
            tx        <= 1'b0;
            tx_active <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // Next bit is presented from the pre-shift value to keep tx registered.
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            tx_active <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          tx        <= 1'b1;
          tx_active <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
